// File: rtl/rgb_pwm_capture.sv
// Three-channel PWM period / high-time capture with per-channel synchronizers
// and a stuck-level timeout that reports the held level on stuck_o.
module rgb_pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         pwm_in,
    output logic [3*CNT_W-1:0] period_o,
    output logic [3*CNT_W-1:0] high_o,
    output logic [2:0]         valid_o,
    output logic [2:0]         stuck_o
);

    typedef enum logic {
        ST_ACQ = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   prev_q;
        logic                   s;
        logic                   rise;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       pcnt_q, pcnt_d;
        logic [CNT_W-1:0]       hcnt_q, hcnt_d;
        logic [CNT_W-1:0]       period_q, period_d;
        logic [CNT_W-1:0]       high_q, high_d;
        logic                   valid_q, valid_d;
        logic                   stuck_q, stuck_d;

        assign sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in[ch]};
        assign s      = sync_q[SYNC_STAGES-1];
        assign rise   = s & ~prev_q;

        // A rise takes priority over the timeout, so a period of exactly CNT_MAX is legal.
        always_comb begin
            state_d  = state_q;
            pcnt_d   = pcnt_q + CNT_ONE;
            hcnt_d   = hcnt_q + {{(CNT_W-1){1'b0}}, s};
            period_d = period_q;
            high_d   = high_q;
            stuck_d  = stuck_q;
            valid_d  = 1'b0;
            if (rise) begin
                pcnt_d  = CNT_ONE;
                hcnt_d  = CNT_ONE;
                state_d = ST_RUN;
                if (state_q == ST_RUN) begin
                    period_d = pcnt_q;
                    high_d   = hcnt_q;
                    stuck_d  = 1'b0;
                    valid_d  = 1'b1;
                end
            end else if (pcnt_q == CNT_MAX) begin
                period_d = '0;
                high_d   = s ? CNT_MAX : '0;
                stuck_d  = s;
                valid_d  = 1'b1;
                pcnt_d   = '0;
                hcnt_d   = '0;
                state_d  = ST_ACQ;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q   <= '0;
                prev_q   <= 1'b0;
                state_q  <= ST_ACQ;
                pcnt_q   <= '0;
                hcnt_q   <= '0;
                period_q <= '0;
                high_q   <= '0;
                valid_q  <= 1'b0;
                stuck_q  <= 1'b0;
            end else begin
                sync_q   <= sync_d;
                prev_q   <= s;
                state_q  <= state_d;
                pcnt_q   <= pcnt_d;
                hcnt_q   <= hcnt_d;
                period_q <= period_d;
                high_q   <= high_d;
                valid_q  <= valid_d;
                stuck_q  <= stuck_d;
            end
        end

        assign period_o[ch*CNT_W +: CNT_W] = period_q;
        assign high_o[ch*CNT_W +: CNT_W]   = high_q;
        assign valid_o[ch]                 = valid_q;
        assign stuck_o[ch]                 = stuck_q;
    end

endmodule

// File: tb/tb_rgb_pwm_capture.sv
// Directed bench for rgb_pwm_capture at CNT_W=8 so timeouts occur every few
// hundred cycles; strobes are checked against per-channel expected queues.
module tb_rgb_pwm_capture;

  localparam int W = 8;
  localparam int E = 2 * W + 1;

  logic           clk;
  logic           rst;
  logic           pwm_r, pwm_g, pwm_b;
  logic [2:0]     pwm_in;
  logic [3*W-1:0] period_o;
  logic [3*W-1:0] high_o;
  logic [2:0]     valid_o;
  logic [2:0]     stuck_o;

  int n_assert = 0;
  int n_fail   = 0;
  int sim_cnt  = 0;
  logic [2:0] prev_v = '0;

  logic [E-1:0] exp_q0[$];
  logic [E-1:0] exp_q1[$];
  logic [E-1:0] exp_q2[$];

  assign pwm_in = {pwm_b, pwm_g, pwm_r};

  rgb_pwm_capture #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (pwm_in),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .stuck_o  (stuck_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int ch, input int per, input int hi, input logic st);
    logic [W-1:0] p8, h8;
    p8 = per[W-1:0];
    h8 = hi[W-1:0];
    case (ch)
      0: exp_q0.push_back({p8, h8, st});
      1: exp_q1.push_back({p8, h8, st});
      default: exp_q2.push_back({p8, h8, st});
    endcase
  endtask

  task automatic set_pwm(input int ch, input logic v);
    case (ch)
      0: pwm_r = v;
      1: pwm_g = v;
      default: pwm_b = v;
    endcase
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver: n periods; every rise after the first reports the previous period
  task automatic pwm_gen(input int ch, input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      if (k >= 1) push_exp(ch, per, hi, 1'b0);
      set_pwm(ch, 1'b1);
      wait_cycles(hi);
      set_pwm(ch, 1'b0);
      wait_cycles(per - hi);
    end
  endtask

  task automatic do_reset(input logic r, input logic g, input logic b);
    rst = 1'b0;
    pwm_r = r;
    pwm_g = g;
    pwm_b = b;
    wait_cycles(3);
    rst = 1'b1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, " q0 empty"}, 64'(exp_q0.size()), 64'd0);
    check({tag, " q1 empty"}, 64'(exp_q1.size()), 64'd0);
    check({tag, " q2 empty"}, 64'(exp_q2.size()), 64'd0);
  endtask

  // scoreboard
  task automatic check_strobe(input int ch);
    logic [E-1:0] obs;
    logic [E-1:0] expv;
    int sz;
    obs = {period_o[ch*W +: W], high_o[ch*W +: W], stuck_o[ch]};
    case (ch)
      0: sz = exp_q0.size();
      1: sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    check($sformatf("ch%0d strobe expected", ch), 64'(sz > 0), 64'd1);
    check($sformatf("ch%0d strobe one cycle", ch), 64'(prev_v[ch]), 64'd0);
    if (sz > 0) begin
      case (ch)
        0: expv = exp_q0.pop_front();
        1: expv = exp_q1.pop_front();
        default: expv = exp_q2.pop_front();
      endcase
      check($sformatf("ch%0d {period,high,stuck}", ch), 64'(obs), 64'(expv));
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < 3; i++)
        if (valid_o[i]) check_strobe(i);
      if (valid_o[1] && valid_o[2]) sim_cnt++;
      prev_v = valid_o;
    end else begin
      prev_v = '0;
    end
  end

  initial begin
    rst = 1'b0;
    pwm_r = 1'b0;
    pwm_g = 1'b0;
    pwm_b = 1'b0;
    wait_cycles(2);
    check("reset period_o", 64'(period_o), 64'd0);
    check("reset high_o", 64'(high_o), 64'd0);
    check("reset valid_o", 64'(valid_o), 64'd0);
    check("reset stuck_o", 64'(stuck_o), 64'd0);

    // R 100/50, G 200/1, B 200/199 all starting together
    do_reset(1'b0, 1'b0, 1'b0);
    sim_cnt = 0;
    fork
      pwm_gen(0, 100, 50, 8);
      pwm_gen(1, 200, 1, 4);
      pwm_gen(2, 200, 199, 4);
    join
    wait_cycles(2);
    check_empty("t1");
    check("t1 simultaneous G/B strobes", 64'(sim_cnt), 64'd3);
    check("t1 R period hold", 64'(period_o[0 +: W]), 64'd100);
    check("t1 R high hold", 64'(high_o[0 +: W]), 64'd50);
    check("t1 G period hold", 64'(period_o[W +: W]), 64'd200);
    check("t1 G high hold", 64'(high_o[W +: W]), 64'd1);
    check("t1 B high hold", 64'(high_o[2*W +: W]), 64'd199);

    // B held high from reset, R/G held low; then R resumes after its timeout
    do_reset(1'b0, 1'b0, 1'b1);
    push_exp(0, 0, 0, 1'b0);
    push_exp(0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 0, 0, 1'b0);
      push_exp(2, 0, 255, 1'b1);
    end
    wait_cycles(600);
    check("t3 stuck_o B", 64'(stuck_o[2]), 64'd1);
    check("t3 B period", 64'(period_o[2*W +: W]), 64'd0);
    check("t4 R high after low timeout", 64'(high_o[0 +: W]), 64'd0);
    pwm_gen(0, 100, 50, 2);
    wait_cycles(5);
    check_empty("t3/t4");
    check("t4 R period after resume", 64'(period_o[0 +: W]), 64'd100);
    check("t4 stuck_o", 64'(stuck_o), 64'b100);

    // asynchronous reset mid-period on G
    do_reset(1'b0, 1'b0, 1'b0);
    pwm_gen(1, 100, 30, 2);
    wait_cycles(20);
    check("t5 G period before rst", 64'(period_o[W +: W]), 64'd100);
    #2;
    rst = 1'b0;
    #1;
    check("t5 async period_o", 64'(period_o), 64'd0);
    check("t5 async high_o", 64'(high_o), 64'd0);
    check("t5 async valid/stuck", 64'({valid_o, stuck_o}), 64'd0);
    wait_cycles(3);
    rst = 1'b1;
    push_exp(0, 0, 0, 1'b0);
    push_exp(2, 0, 0, 1'b0);
    pwm_gen(1, 100, 30, 3);
    wait_cycles(5);
    check_empty("t5");

    // rise exactly CNT_MAX cycles after the previous one
    do_reset(1'b0, 1'b0, 1'b0);
    push_exp(1, 0, 0, 1'b0);
    push_exp(2, 0, 0, 1'b0);
    pwm_gen(0, 255, 10, 1);
    push_exp(0, 255, 10, 1'b0);
    pwm_r = 1'b1;
    wait_cycles(6);
    check_empty("t6");
    check("t6 R period max", 64'(period_o[0 +: W]), 64'd255);
    check("t6 R stuck", 64'(stuck_o[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
